// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for the memory arbiter
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if;

    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;

    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arb_dff.sv
// rtl/mem_arb_dff.sv - enabled data register with synchronous active-low clear
module mem_arb_dff #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load when enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - winner select; MEM_ARB_RR_EN switches ties to round-robin
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Lone requests always win; a tie goes to DM, or to whoever was not served last
    always_comb begin
        grant = if_req | dm_req;
        owner = dm_req ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req && dm_req) begin
            owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/DM arbiter for a fixed-latency memory; MEM_ARB_RR_EN enables round-robin ties
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] cnt;
    logic             grant;
    logic             win;
    logic             take;
    logic             unal;
    logic             cap_en;
    logic             mem_en_q;
    logic             mem_wr_q;
    logic             if_done_q;
    logic             dm_done_q;
    logic             err_q;
    logic [15:0]      req_addr;
    logic [15:0]      req_wdata;
    logic [15:0]      mem_addr_q;
    logic [15:0]      rdata_d;

    mem_arb_grant u_grant (
        .if_req     (bus.if_req),
        .dm_req     (bus.dm_req),
        .last_owner (last_owner),
        .grant      (grant),
        .owner      (win)
    );

    assign take      = (state == IDLE) && grant;
    assign req_addr  = (win == OWN_DM) ? bus.dm_addr : bus.if_addr;
    assign req_wdata = (win == OWN_DM) ? bus.dm_wdata : 16'h0000;

    // An odd address never reaches the memory; its result is forced to zero
    assign unal    = mem_addr_q[0];
    assign cap_en  = (state == BUSY) && (unal || ((cnt == '0) && !mem_wr_q));
    assign rdata_d = unal ? 16'h0000 : bus.mem_rdata;

    mem_arb_dff #(.W(16)) u_mem_addr (
        .clk (clk), .rst (rst), .en (take), .d (req_addr), .q (mem_addr_q)
    );

    mem_arb_dff #(.W(16)) u_mem_wdata (
        .clk (clk), .rst (rst), .en (take), .d (req_wdata), .q (bus.mem_wdata)
    );

    mem_arb_dff #(.W(16)) u_if_rdata (
        .clk (clk), .rst (rst), .en (cap_en && (owner == OWN_IF)), .d (rdata_d), .q (bus.if_rdata)
    );

    mem_arb_dff #(.W(16)) u_dm_rdata (
        .clk (clk), .rst (rst), .en (cap_en && (owner == OWN_DM)), .d (rdata_d), .q (bus.dm_rdata)
    );

`ifndef MEM_ARB_RR_EN
    assign last_owner = OWN_IF;
`endif

    // Access sequencer: grant, strobe once, count out the latency, pulse done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_DM;
            cnt       <= '0;
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= OWN_IF;
`endif
        end else begin
            mem_en_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= win;
                        mem_wr_q <= (win == OWN_DM) && bus.dm_wr;
                        mem_en_q <= ~req_addr[0];
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        state    <= BUSY;
`ifdef MEM_ARB_RR_EN
                        last_owner <= win;
`endif
                    end
                end
                BUSY: begin
                    if (unal || (cnt == '0)) begin
                        state     <= DONE;
                        if_done_q <= (owner == OWN_IF);
                        dm_done_q <= (owner == OWN_DM);
                        err_q     <= unal;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en   = mem_en_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.if_done  = if_done_q;
    assign bus.dm_done  = dm_done_q;
    assign bus.err      = err_q;
    assign bus.if_stall = bus.if_req & ~if_done_q;
    assign bus.dm_stall = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter; honours MEM_ARB_RR_EN
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int L = 4;

    typedef struct { logic port; logic wr; logic [15:0] addr; logic [15:0] wdata; } req_t;
    typedef struct { logic port; int cyc; logic [15:0] rdata; logic err; } done_t;
    typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LAT(L), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    mon_en   = 0;
    done_t done_q[$];
    mem_t  memx_q[$];
    logic [15:0] model_mem [bit [15:0]];
    logic [15:0] store     [bit [15:0]];
    logic [15:0] exp_rdata [2];
    logic        last_own;

    bit          pend = 0;
    int          age  = 0;
    logic [15:0] paddr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory macro: write on the strobe, read data present only MEM_LAT-1 cycles after it
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
            pend  = 1;
            age   = 0;
            paddr = bus.mem_addr;
        end else if (pend) begin
            age++;
        end
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b1) store[bus.mem_addr] = bus.mem_wdata;
        if (pend && age == L - 1) begin
            bus.mem_rdata = store.exists(paddr) ? store[paddr] : init_val(paddr);
            pend = 0;
        end else begin
            bus.mem_rdata = 16'($urandom);
        end
    end

    // Monitor: every strobe and every done must match the next scoreboard entry
    always @(negedge clk) begin
        if (mon_en) begin
            mem_t  m;
            done_t d;
            chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~bus.if_done));
            chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req & ~bus.dm_done));
            if (bus.mem_en) begin
                chk("mem_en_expected", 32'(memx_q.size() != 0), 32'd1);
                if (memx_q.size() != 0) begin
                    m = memx_q.pop_front();
                    chk("mem_wr", 32'(bus.mem_wr), 32'(m.wr));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                    if (m.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
                end
            end
            if (bus.if_done || bus.dm_done) begin
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                chk("done_single", 32'(bus.if_done & bus.dm_done), 32'd0);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    chk("done_port", 32'(bus.dm_done), 32'(d.port));
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("err", 32'(bus.err), 32'(d.err));
                    chk("rdata", 32'(d.port ? bus.dm_rdata : bus.if_rdata), 32'(d.rdata));
                end
            end else begin
                chk("err_without_done", 32'(bus.err), 32'd0);
            end
        end
    end

    function automatic req_t mk(input logic port, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata);
        req_t r;
        r.port = port; r.wr = wr; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req(input logic port);
        req_t r;
        r.port  = port;
        r.wr    = (port == OWN_DM) ? 1'($urandom_range(0, 1)) : 1'b0;
        r.addr  = 16'h0040 + 16'($urandom_range(0, 7) * 2);
        if ($urandom_range(0, 7) == 0) r.addr[0] = 1'b1;
        r.wdata = 16'($urandom);
        return r;
    endfunction

    // Winner of a simultaneous request
    function automatic logic pick_first();
`ifdef MEM_ARB_RR_EN
        return (last_own == OWN_IF) ? OWN_DM : OWN_IF;
`else
        return OWN_DM;
`endif
    endfunction

    // One access granted at sample cycle s; returns the cycle its done pulses
    function automatic int model_access(input req_t r, input int s);
        done_t d;
        mem_t  m;
        d.port = r.port;
        d.err  = r.addr[0];
        d.cyc  = r.addr[0] ? s + 2 : s + L + 1;
        if (r.addr[0]) begin
            exp_rdata[r.port] = 16'h0000;
        end else begin
            m.wr = r.wr; m.addr = r.addr; m.wdata = r.wdata;
            memx_q.push_back(m);
            if (r.wr) model_mem[r.addr] = r.wdata;
            else exp_rdata[r.port] = model_mem.exists(r.addr) ? model_mem[r.addr] : init_val(r.addr);
        end
        d.rdata = exp_rdata[r.port];
        done_q.push_back(d);
        last_own = r.port;
        return d.cyc;
    endfunction

    // kind: 0 = IF alone, 1 = DM alone, 2 = both in the same cycle
    task automatic run_round(input int kind, input bit drop_early, input req_t ri, input req_t rd);
        int   t;
        int   dc;
        bit   if_p;
        bit   dm_p;
        logic first;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        t    = cyc;
        if_p = (kind != 1);
        dm_p = (kind != 0);
        if (if_p) begin bus.if_req = 1'b1; bus.if_addr = ri.addr; end
        if (dm_p) begin
            bus.dm_req = 1'b1; bus.dm_wr = rd.wr; bus.dm_addr = rd.addr; bus.dm_wdata = rd.wdata;
        end
        if (kind == 0) dc = model_access(ri, t);
        else if (kind == 1) dc = model_access(rd, t);
        else begin
            first = pick_first();
            if (first == OWN_DM) begin dc = model_access(rd, t); dc = model_access(ri, dc + 1); end
            else begin dc = model_access(ri, t); dc = model_access(rd, dc + 1); end
        end
        for (int n = 0; n < 4 * L + 20 && (if_p || dm_p); n++) begin
            @(posedge clk); #1;
            if (bus.if_done) begin bus.if_req = 1'b0; bus.if_addr = 16'($urandom); if_p = 0; end
            if (bus.dm_done) begin
                bus.dm_req = 1'b0; bus.dm_wr = 1'($urandom); bus.dm_addr = 16'($urandom);
                bus.dm_wdata = 16'($urandom); dm_p = 0;
            end
            if (drop_early && n == 0 && kind != 2) begin
                bus.if_req = 1'b0; bus.dm_req = 1'b0;
                bus.if_addr = 16'($urandom); bus.dm_addr = 16'($urandom); bus.dm_wr = 1'($urandom);
            end
        end
        if (if_p || dm_p) begin
            checks++;
            failures++;
            $display("FAIL round_timeout: got no done by cycle %0d expected by cycle %0d", cyc, dc);
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
        chk({tag, "_dm_done"}, 32'(bus.dm_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_if_rdata"}, 32'(bus.if_rdata), 32'd0);
        chk({tag, "_dm_rdata"}, 32'(bus.dm_rdata), 32'd0);
    endtask

    // Reset lands in the middle of an IF read: no done may follow
    task automatic reset_mid();
        mem_t m;
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0044;
        m.wr = 1'b0; m.addr = 16'h0044; m.wdata = 16'h0000;
        memx_q.push_back(m);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.if_req = 1'b0;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        last_own = OWN_IF;
        @(negedge clk);
        check_reset("reset_mid");
        repeat (L + 4) @(posedge clk);
    endtask

    initial begin
        req_t r_if;
        req_t r_dm;
        int   kind;
        bus.if_req = 1'b0; bus.if_addr = 16'h0; bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
        bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        last_own = OWN_IF;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1;

        r_if = mk(OWN_IF, 1'b0, 16'h0010, 16'h0000);
        r_dm = mk(OWN_DM, 1'b1, 16'h0040, 16'hBEEF);
        run_round(0, 0, r_if, r_dm);
        run_round(1, 0, r_if, r_dm);
        r_dm.wr = 1'b0;
        run_round(1, 0, r_if, r_dm);
        r_if.addr = 16'h0040;
        r_dm = mk(OWN_DM, 1'b1, 16'h0040, 16'h1357);
        run_round(2, 0, r_if, r_dm);
        run_round(2, 0, r_if, r_dm);
        r_dm = mk(OWN_DM, 1'b0, 16'h0041, 16'h0000);
        run_round(1, 0, r_if, r_dm);
        r_dm = mk(OWN_DM, 1'b0, 16'h0042, 16'h0000);
        run_round(1, 1, r_if, r_dm);

        reset_mid();
        r_if = mk(OWN_IF, 1'b0, 16'h0044, 16'h0000);
        run_round(0, 0, r_if, r_dm);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            run_round(kind, $urandom_range(0, 3) == 0, rand_req(OWN_IF), rand_req(OWN_DM));
        end

        repeat (L + 6) @(posedge clk);
        @(negedge clk);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("mem_q_drained", 32'(memx_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
